// File: rtl/button_encoder_p1_pkg.sv
// ---------------------------------------------------------------------------
// btn_codes_p1_pkg
// Shared definitions for the three-button encoder: the 2-bit event codes
// driven on the up/down/toggle outputs and the per-channel FSM states.
// No ports; imported by the interface, the channel and the top level.
// ---------------------------------------------------------------------------
package btn_codes_p1_pkg;

  // Event code carried on each output for exactly one cycle per event
  typedef logic [1:0] code_t;

  localparam code_t CODE_IDLE  = 2'b00;
  localparam code_t CODE_PRESS = 2'b01;
  localparam code_t CODE_HOLD  = 2'b11;

  // Per-button debounce / hold state machine
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_HELD       = 3'd3,
    ST_RELEASE_DB = 3'd4
  } chan_state_e;

endpackage

// File: rtl/button_encoder_p1_if.sv
// ---------------------------------------------------------------------------
// button_encoder_p1_if
// Bundles the raw button inputs and the encoded event outputs.
//   btn_up / btn_down / btn_toggle : raw, asynchronous, bouncing buttons
//   up / down / toggle             : 2-bit registered event codes
// master : the side that drives the buttons and watches the codes
// slave  : the encoder itself
// ---------------------------------------------------------------------------
interface button_encoder_p1_if;
  import btn_codes_p1_pkg::*;

  logic  btn_up;
  logic  btn_down;
  logic  btn_toggle;
  code_t up;
  code_t down;
  code_t toggle;

  modport master (
    output btn_up, btn_down, btn_toggle,
    input  up, down, toggle
  );

  modport slave (
    input  btn_up, btn_down, btn_toggle,
    output up, down, toggle
  );

endinterface

// File: rtl/button_encoder_p1_channel.sv
// ---------------------------------------------------------------------------
// btn_channel_p1
// One button channel: 2-flop synchronizer, debounce counter and the
// IDLE/PRESS_DB/PRESSED/HELD/RELEASE_DB state machine. Emits a registered
// one-cycle event code (press, and hold-repeat when HOLD_EN is set).
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   i_btn  : raw asynchronous button input
//   o_code : one-cycle event code (CODE_IDLE otherwise)
// ---------------------------------------------------------------------------
module btn_channel_p1
  import btn_codes_p1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32,
  parameter bit HOLD_EN         = 1'b1
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  i_btn,
  output code_t o_code
);

  // Counters are sized for the largest of the three cycle parameters
  localparam int MAX_P = (DEBOUNCE_CYCLES > HOLD_CYCLES)
                       ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
                       : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             w_in;
  chan_state_e      r_state;
  chan_state_e      w_nextState;
  logic [CNT_W-1:0] r_dbCnt;
  logic [CNT_W-1:0] w_dbNext;
  logic [CNT_W-1:0] r_holdCnt;
  logic [CNT_W-1:0] w_holdNext;
  logic [CNT_W-1:0] r_repCnt;
  logic [CNT_W-1:0] w_repNext;
  logic             r_fromHeld;
  logic             w_fromHeldNext;
  logic             w_holdPhase;
  code_t            r_code;
  code_t            w_codeNext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_in = r_sync[1];

  // While glitching low from HELD we must keep running the repeat timer
  // rather than the hold timer once the 1 returns
  assign w_holdPhase = (r_state == ST_HELD) ||
                       ((r_state == ST_RELEASE_DB) && r_fromHeld);

  // Two-flop synchronizer, then the FSM/counter/event registers; reset
  // clears everything so a button still held afterwards debounces afresh
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync     <= 2'b00;
      r_state    <= ST_IDLE;
      r_dbCnt    <= '0;
      r_holdCnt  <= '0;
      r_repCnt   <= '0;
      r_fromHeld <= 1'b0;
      r_code     <= CODE_IDLE;
    end else begin
      r_sync     <= {r_sync[0], i_btn};
      r_state    <= w_nextState;
      r_dbCnt    <= w_dbNext;
      r_holdCnt  <= w_holdNext;
      r_repCnt   <= w_repNext;
      r_fromHeld <= w_fromHeldNext;
      r_code     <= w_codeNext;
    end
  end

  // Next-state and event logic. The hold counter only advances on 1
  // samples and survives a short low glitch; RELEASE_DB falls back to
  // whichever state it came from as soon as a 1 is seen.
  always_comb begin
    w_nextState    = r_state;
    w_dbNext       = r_dbCnt;
    w_holdNext     = r_holdCnt;
    w_repNext      = r_repCnt;
    w_fromHeldNext = r_fromHeld;
    w_codeNext     = CODE_IDLE;

    case (r_state)
      ST_IDLE: begin
        if (w_in) begin
          w_nextState = ST_PRESS_DB;
          w_dbNext    = '0;
        end
      end

      ST_PRESS_DB: begin
        if (!w_in) begin
          w_nextState = ST_IDLE;
          w_dbNext    = '0;
        end else if (r_dbCnt == DB_LAST) begin
          w_nextState    = ST_PRESSED;
          w_codeNext     = CODE_PRESS;
          w_dbNext       = '0;
          w_holdNext     = '0;
          w_repNext      = '0;
          w_fromHeldNext = 1'b0;
        end else begin
          w_dbNext = satInc(r_dbCnt);
        end
      end

      ST_PRESSED, ST_HELD, ST_RELEASE_DB: begin
        if (!w_in) begin
          if (r_state != ST_RELEASE_DB) begin
            w_nextState    = ST_RELEASE_DB;
            w_dbNext       = '0;
            w_fromHeldNext = (r_state == ST_HELD);
          end else if (r_dbCnt == DB_LAST) begin
            w_nextState    = ST_IDLE;
            w_dbNext       = '0;
            w_holdNext     = '0;
            w_repNext      = '0;
            w_fromHeldNext = 1'b0;
          end else begin
            w_dbNext = satInc(r_dbCnt);
          end
        end else begin
          w_dbNext = '0;
          if (w_holdPhase) begin
            w_nextState = ST_HELD;
            if (r_repCnt == REP_LAST) begin
              w_codeNext = CODE_HOLD;
              w_repNext  = '0;
            end else begin
              w_repNext = satInc(r_repCnt);
            end
          end else begin
            w_nextState = ST_PRESSED;
            if (HOLD_EN && (r_holdCnt == HOLD_LAST)) begin
              w_nextState = ST_HELD;
              w_codeNext  = CODE_HOLD;
              w_repNext   = '0;
            end else if (HOLD_EN) begin
              w_holdNext = satInc(r_holdCnt);
            end
          end
        end
      end

      default: begin
        w_nextState = ST_IDLE;
        w_dbNext    = '0;
      end
    endcase
  end

  assign o_code = r_code;

endmodule

// File: rtl/button_encoder_p1.sv
// ---------------------------------------------------------------------------
// button_encoder_p1
// Three debounced buttons (up, down, toggle) encoded into one-cycle event
// codes. Up and down report press and hold-repeat; toggle reports press
// only. At most one output is active per cycle (up > down > toggle); losing
// events are dropped.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : button_encoder_p1_if.slave (raw buttons in, codes out)
// ---------------------------------------------------------------------------
module button_encoder_p1
  import btn_codes_p1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32
) (
  input logic                clock,
  input logic                reset,
  button_encoder_p1_if.slave bus
);

  code_t w_upCode;
  code_t w_downCode;
  code_t w_toggleCode;
  code_t w_upArb;
  code_t w_downArb;
  code_t w_toggleArb;
  code_t r_up;
  code_t r_down;
  code_t r_toggle;

  btn_channel_p1 #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .HOLD_EN         (1'b1)
  ) u_upChannel (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (bus.btn_up),
    .o_code (w_upCode)
  );

  btn_channel_p1 #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .HOLD_EN         (1'b1)
  ) u_downChannel (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (bus.btn_down),
    .o_code (w_downCode)
  );

  btn_channel_p1 #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .HOLD_EN         (1'b0)
  ) u_toggleChannel (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (bus.btn_toggle),
    .o_code (w_toggleCode)
  );

  // Fixed priority up > down > toggle; a lower channel's event that
  // collides with a higher one is simply lost
  always_comb begin
    w_upArb     = w_upCode;
    w_downArb   = CODE_IDLE;
    w_toggleArb = CODE_IDLE;
    if (w_upCode == CODE_IDLE) begin
      w_downArb = w_downCode;
      if (w_downCode == CODE_IDLE) begin
        w_toggleArb = w_toggleCode;
      end
    end
  end

  // Output registers so the codes leave the block glitch-free
  always_ff @(posedge clock) begin
    if (reset) begin
      r_up     <= CODE_IDLE;
      r_down   <= CODE_IDLE;
      r_toggle <= CODE_IDLE;
    end else begin
      r_up     <= w_upArb;
      r_down   <= w_downArb;
      r_toggle <= w_toggleArb;
    end
  end

  assign bus.up     = r_up;
  assign bus.down   = r_down;
  assign bus.toggle = r_toggle;

endmodule

// File: tb/tb_button_encoder_p1.sv
// ---------------------------------------------------------------------------
// tb_button_encoder_p1
// Directed bench for button_encoder_p1 with DEBOUNCE=4, HOLD=16, REPEAT=8.
// Each test drives raw buttons cycle by cycle; edge 0 is the first rising
// edge that samples the new stimulus. Expected events {edge, up, down,
// toggle} are queued up front and popped whenever an output is active or
// an expected event is due.
// ---------------------------------------------------------------------------
module tb_button_encoder_p1;
  import btn_codes_p1_pkg::*;

  localparam int DB   = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  typedef struct {
    int         edgeIdx;
    logic [5:0] codes;
    string      tag;
  } expEvt_t;

  logic    clock = 1'b0;
  logic    reset;
  expEvt_t expQ[$];
  int      nCompared   = 0;
  int      nMismatched = 0;
  int      curEdge     = 0;

  button_encoder_p1_if bus ();

  button_encoder_p1 #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  task automatic expectEvent(input int e, input code_t u, input code_t d,
                             input code_t t, input string tag);
    expEvt_t ev;
    ev.edgeIdx = e;
    ev.codes   = {u, d, t};
    ev.tag     = tag;
    expQ.push_back(ev);
  endtask

  // Compare the outputs produced by edge curEdge against the scoreboard
  task automatic checkOutput();
    logic [5:0] obs;
    expEvt_t    ev;
    obs = {bus.up, bus.down, bus.toggle};
    if (obs !== 6'b0 || (expQ.size() != 0 && expQ[0].edgeIdx <= curEdge)) begin
      if (expQ.size() == 0) begin
        nCompared++;
        assert (obs === 6'b0) else begin
          nMismatched++;
          $error("[TB] FAIL unexpected_event edge=%0d observed=%b expected=%b",
                 curEdge, obs, 6'b0);
        end
      end else begin
        ev = expQ.pop_front();
        nCompared++;
        assert (obs === ev.codes) else begin
          nMismatched++;
          $error("[TB] FAIL %s_code edge=%0d observed=%b expected=%b",
                 ev.tag, curEdge, obs, ev.codes);
        end
        nCompared++;
        assert (curEdge === ev.edgeIdx) else begin
          nMismatched++;
          $error("[TB] FAIL %s_cycle observed=%0d expected=%0d",
                 ev.tag, curEdge, ev.edgeIdx);
        end
      end
    end
  endtask

  // Drive one cycle away from the clock edge and sample #1 after it
  task automatic applyStimulus(input logic u, input logic d, input logic t,
                               input logic r);
    @(negedge clock);
    bus.btn_up     = u;
    bus.btn_down   = d;
    bus.btn_toggle = t;
    reset          = r;
    @(posedge clock);
    #1;
    if (r) begin
      nCompared++;
      assert ({bus.up, bus.down, bus.toggle} === 6'b0) else begin
        nMismatched++;
        $error("[TB] FAIL reset_outputs edge=%0d observed=%b expected=%b",
               curEdge, {bus.up, bus.down, bus.toggle}, 6'b0);
      end
    end else begin
      checkOutput();
    end
    curEdge++;
  endtask

  task automatic endTest(input string tag);
    nCompared++;
    assert (expQ.size() === 0) else begin
      nMismatched++;
      $error("[TB] FAIL %s_missing observed=%0d expected=%0d",
             tag, expQ.size(), 0);
      expQ.delete();
    end
  endtask

  initial begin
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_toggle = 1'b0;
    reset          = 1'b1;

    // Power-on reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Clean 10-cycle up pulse: single press at edge 7
    $display("[TB] clean up pulse");
    curEdge = 0;
    expectEvent(7, CODE_PRESS, CODE_IDLE, CODE_IDLE, "pulse_press");
    for (int k = 0; k < 25; k++) applyStimulus(k < 10, 1'b0, 1'b0, 1'b0);
    endTest("pulse");

    // Bouncing down button never passes debounce
    $display("[TB] bouncing down");
    curEdge = 0;
    for (int k = 0; k < 15; k++)
      applyStimulus(1'b0, (k < 6) && (k % 2 == 0), 1'b0, 1'b0);
    endTest("bounce");

    // Up held 40 cycles: press 7, holds 23/31/39
    $display("[TB] up held");
    curEdge = 0;
    expectEvent(7,  CODE_PRESS, CODE_IDLE, CODE_IDLE, "held_press");
    expectEvent(23, CODE_HOLD,  CODE_IDLE, CODE_IDLE, "held_hold1");
    expectEvent(31, CODE_HOLD,  CODE_IDLE, CODE_IDLE, "held_hold2");
    expectEvent(39, CODE_HOLD,  CODE_IDLE, CODE_IDLE, "held_hold3");
    for (int k = 0; k < 60; k++) applyStimulus(k < 40, 1'b0, 1'b0, 1'b0);
    endTest("held");

    // Toggle held 40 cycles: one press, never a hold code
    $display("[TB] toggle held");
    curEdge = 0;
    expectEvent(7, CODE_IDLE, CODE_IDLE, CODE_PRESS, "toggle_press");
    for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b0, k < 40, 1'b0);
    endTest("toggle");

    // Up and down together: up wins, down's press is dropped
    $display("[TB] up/down collision");
    curEdge = 0;
    expectEvent(7, CODE_PRESS, CODE_IDLE, CODE_IDLE, "collide_press");
    for (int k = 0; k < 25; k++) applyStimulus(k < 10, k < 10, 1'b0, 1'b0);
    endTest("collide");

    // Single low sample while pressed: hold timer keeps its count, so the
    // first hold lands one cycle late (24) and the repeat follows at 32
    $display("[TB] glitch during hold count");
    curEdge = 0;
    expectEvent(7,  CODE_PRESS, CODE_IDLE, CODE_IDLE, "glitch_press");
    expectEvent(24, CODE_HOLD,  CODE_IDLE, CODE_IDLE, "glitch_hold1");
    expectEvent(32, CODE_HOLD,  CODE_IDLE, CODE_IDLE, "glitch_hold2");
    for (int k = 0; k < 45; k++)
      applyStimulus((k < 30) && (k != 12), 1'b0, 1'b0, 1'b0);
    endTest("glitch");

    // Reset pulse at edge 5 mid-press: fresh press from edge 6, event at 13
    $display("[TB] reset mid-press");
    curEdge = 0;
    expectEvent(13, CODE_PRESS, CODE_IDLE, CODE_IDLE, "rst_press");
    for (int k = 0; k < 35; k++) applyStimulus(k < 20, 1'b0, 1'b0, k == 5);
    endTest("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
